// File: rtl/instr_encoder.sv
// Encodes RV32-style field tuples (R/I/S/B/U/J) into 32-bit instruction words and
// buffers {err, word} in a small circular FIFO with valid/ready handshakes on both sides.
module instr_encoder #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [2:0]  func3,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [6:0]  func7,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic [15:0] count
);

  localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_OCC = (AW + 1)'(FIFO_DEPTH);
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  // Returns {err, word}; only the fields belonging to the selected format are read.
  function automatic logic [32:0] encode(
    input logic [2:0]  f,
    input logic [6:0]  op,
    input logic [4:0]  d,
    input logic [2:0]  f3,
    input logic [4:0]  s1,
    input logic [4:0]  s2,
    input logic [6:0]  f7,
    input logic [31:0] im
  );
    logic [32:0] r;
    r = {1'b1, NOP_WORD};
    case (f)
      FMT_R: r = {1'b0, f7, s2, s1, f3, d, op};
      FMT_I: r = {1'b0, im[11:0], s1, f3, d, op};
      FMT_S: r = {1'b0, im[11:5], s2, s1, f3, im[4:0], op};
      FMT_B: r = {1'b0, im[12], im[10:5], s2, s1, f3, im[4:1], im[11], op};
      FMT_U: r = {1'b0, im[31:12], d, op};
      FMT_J: r = {1'b0, im[20], im[10:1], im[11], im[19:12], d, op};
      default: r = {1'b1, NOP_WORD};
    endcase
    return r;
  endfunction

  logic [32:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr, rptr_nx;
  logic [AW:0]   occ, occ_nx;
  logic          full, empty, push, pop;
  logic [32:0]   enc_p0;
  logic [32:0]   head_p1, head_nx;

  assign full      = (occ == FULL_OCC);
  assign empty     = (occ == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && !full;
  assign pop       = !empty && out_ready;

  assign enc_p0 = encode(fmt, opcode, rd, func3, rs1, rs2, func7, imm);

  always_comb begin
    rptr_nx = pop ? rptr + 1'b1 : rptr;
    occ_nx  = occ;
    if (push && !pop)
      occ_nx = occ + 1'b1;
    else if (!push && pop)
      occ_nx = occ - 1'b1;
  end

  // Head register: when the new head is the entry being written this edge, bypass the array.
  always_comb begin
    head_nx = head_p1;
    if (occ_nx != '0) begin
      if (push && (rptr_nx == wptr))
        head_nx = enc_p0;
      else
        head_nx = mem[rptr_nx];
    end
  end

  // ---- stage p0 -> p1: FIFO write and head update ----
  always_ff @(posedge clk) begin
    if (push)
      mem[wptr] <= enc_p0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      occ     <= '0;
      count   <= '0;
      head_p1 <= '0;
    end else begin
      if (push)
        wptr <= wptr + 1'b1;
      rptr    <= rptr_nx;
      occ     <= occ_nx;
      head_p1 <= head_nx;
      if (pop)
        count <= count + 16'd1;
    end
  end

  assign out_err   = head_p1[32];
  assign out_instr = head_p1[31:0];

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, output buffer entries (power of two, >=2).
REQ-002 SHALL have clk  input  1  rising-edge clock; one clock, reset is synchronous and active-high.
REQ-003 SHALL have rst  input  1  synchronous active-high reset.
REQ-004 SHALL have in_valid  input  1  field tuple valid.
REQ-005 SHALL have in_ready  output  1  encoder can accept a tuple.
REQ-006 SHALL have fmt  input  3  format select: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6-7 illegal.
REQ-007 SHALL have opcode  input  7  major opcode.
REQ-008 SHALL have rd  input  5  destination register.
REQ-009 SHALL have func3  input  3  minor function code.
REQ-010 SHALL have rs1  input  5  source register 1.
REQ-011 SHALL have rs2  input  5  source register 2.
REQ-012 SHALL have func7  input  7  R-type function code.
REQ-013 SHALL have imm  input  32  immediate, already sign-extended/aligned by producer.
REQ-014 SHALL have out_valid  output  1  head entry valid.
REQ-015 SHALL have out_ready  input  1  consumer accepts head.
REQ-016 SHALL have out_instr  output  32  encoded instruction at FIFO head.
REQ-017 SHALL have out_err  output  1  head entry came from an illegal fmt.
REQ-018 SHALL have count  output  16  number of output handshakes since reset.

Function
REQ-019 Input handshake SHALL occur when in_valid && in_ready; in_ready = !full, no combinational dependence on out_ready.
REQ-020 Output handshake SHALL occur when out_valid && out_ready; out_valid = !empty.
REQ-021 Encode SHALL be combinational from inputs; the 33-bit {err, word} SHALL be written to the FIFO on the accepting edge; latency accept-to-out_valid = 1 cycle when empty.
REQ-022 R: {func7, rs2, rs1, func3, rd, opcode}.
REQ-023 I: {imm[11:0], rs1, func3, rd, opcode}.
REQ-024 S: {imm[11:5], rs2, rs1, func3, imm[4:0], opcode}.
REQ-025 B: {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode}; imm[0] ignored.
REQ-026 U: {imm[31:12], rd, opcode}.
REQ-027 J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}; imm[0] ignored.
REQ-028 Fields unused by the selected format SHALL not affect the output.
REQ-029 fmt 6/7 SHALL store word 0x00000013 (NOP) with err=1; legal formats store err=0.
REQ-030 FIFO SHALL be circular: write/read pointers wrap at FIFO_DEPTH; occupancy counter 0..FIFO_DEPTH.
REQ-031 Full: in_ready=0, no write even if out_ready=1 that cycle (no pass-through).
REQ-032 Empty: out_valid=0, out_instr/out_err hold last head value, no pop.
REQ-033 Simultaneous push and pop when neither empty nor full SHALL leave occupancy unchanged and preserve order.
REQ-034 While out_valid && !out_ready, out_instr and out_err SHALL remain stable.
REQ-035 count SHALL increment by 1 per output handshake and wrap 0xFFFF -> 0x0000.

Reset
REQ-036 On rst=1 at a clock edge: pointers and occupancy = 0, out_valid=0, in_ready=1 next cycle, out_instr=0, out_err=0, count=0.
REQ-037 Reset mid-operation SHALL discard all buffered entries; an input handshake coinciding with the reset edge SHALL be dropped.

Verification
REQ-038 fmt=0, opcode=0x33, rd=3, func3=0, rs1=1, rs2=2, func7=0 -> next cycle out_valid=1, out_instr=0x002081B3, out_err=0.
REQ-039 fmt=1, opcode=0x13, rd=1, rs1=0, func3=0, imm=5 -> out_instr=0x00500093; fmt=3, opcode=0x63, rs1=1, rs2=2, func3=0, imm=8 -> 0x00208463.
REQ-040 fmt=5, opcode=0x6F, rd=1, imm=16 -> out_instr=0x010000EF; same with imm=17 -> identical word.
REQ-041 out_ready=0, three back-to-back tuples, FIFO_DEPTH=2 -> in_ready=0 after second accept, third held; release out_ready -> three words in order, count=3.
REQ-042 fmt=6 any fields -> out_instr=0x00000013, out_err=1.
REQ-043 Two entries buffered, assert rst one cycle -> out_valid=0, count=0, in_ready=1; subsequent R-type tuple emerges correctly.
